// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // One read port at the default geometry: address in, captured data out.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } rd_port_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write port, scoreboard set port, two read ports.
//
// Strobe semantics: there is no back-pressure anywhere. wr_en, sb_set and
// rd_en are single-cycle strobes sampled on every rising edge; the register
// file always accepts them. Read results and busy flags are registered and
// hold their value on cycles where rd_en is low.
interface reg_file_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              rd_en;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sb_set;
  logic [ADDR_W-1:0] sb_addr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, busy_cnt
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, busy_cnt
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
// sb_set marks a destination busy, a write clears it; set wins on a tie.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic [ADDR_W:0]   busy_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             set_ok;
  logic             clr_ok;
  logic             inc;
  logic             dec;

  // Register 0 never becomes busy when it is hardwired, so the count tops out
  // at DEPTH-1 in that configuration.
  assign set_ok = sb_set_i && !((ZERO_R0 != 0) && (sb_addr_i == '0));
  assign clr_ok = wr_en_i && !((ZERO_R0 != 0) && (wr_addr_i == '0));

  // Next busy vector and count; only genuine bit transitions move the count.
  always_comb begin
    busy_d = busy_q;
    if (clr_ok) busy_d[wr_addr_i] = 1'b0;
    if (set_ok) busy_d[sb_addr_i] = 1'b1;
    inc = set_ok && !busy_q[sb_addr_i];
    dec = clr_ok && busy_q[wr_addr_i] && !(set_ok && (sb_addr_i == wr_addr_i));
    cnt_d = cnt_q;
    if (inc && !dec) cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc) cnt_d = cnt_q - CNT_W'(1);
  end

  // Busy state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // A read sees the pre-edge busy bit, masked by a write to the same register
  // in this cycle; a same-cycle sb_set is deliberately not visible.
  assign rs1_pend_o = busy_q[rs1_addr_i] && !(wr_en_i && (wr_addr_i == rs1_addr_i));
  assign rs2_pend_o = busy_q[rs2_addr_i] && !(wr_en_i && (wr_addr_i == rs2_addr_i));
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port and a
// pending-write scoreboard (reg_scoreboard).
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to a read port; otherwise reads return the pre-write value.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 1
) (
  input logic         clk,
  input logic         reset_n,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rs1_d;
  logic [DATA_W-1:0] rs2_d;
  logic [DATA_W-1:0] rs1_val_q;
  logic [DATA_W-1:0] rs2_val_q;
  logic              rs1_busy_q;
  logic              rs2_busy_q;
  logic              rs1_pend;
  logic              rs2_pend;
  logic              wr_ok;

  assign wr_ok = bus.wr_en && !((ZERO_R0 != 0) && (bus.wr_addr == '0));

  // Storage array; writes to a hardwired r0 are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read data selection, including optional write-to-read forwarding.
  always_comb begin
    rs1_d = regs_q[bus.rs1_addr];
    rs2_d = regs_q[bus.rs2_addr];
    if ((ZERO_R0 != 0) && (bus.rs1_addr == '0)) rs1_d = '0;
    if ((ZERO_R0 != 0) && (bus.rs2_addr == '0)) rs2_d = '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (bus.wr_addr == bus.rs1_addr)) rs1_d = bus.wr_data;
    if (wr_ok && (bus.wr_addr == bus.rs2_addr)) rs2_d = bus.wr_data;
`endif
  end

  // Read-port output registers; they hold while rd_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      rs1_busy_q <= 1'b0;
      rs2_busy_q <= 1'b0;
    end else if (bus.rd_en) begin
      rs1_val_q  <= rs1_d;
      rs2_val_q  <= rs2_d;
      rs1_busy_q <= rs1_pend;
      rs2_busy_q <= rs2_pend;
    end
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (clk),
    .reset_n    (reset_n),
    .sb_set_i   (bus.sb_set),
    .sb_addr_i  (bus.sb_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .rs1_addr_i (bus.rs1_addr),
    .rs2_addr_i (bus.rs2_addr),
    .rs1_pend_o (rs1_pend),
    .rs2_pend_o (rs2_pend),
    .busy_cnt_o (bus.busy_cnt)
  );

  assign bus.rs1_val  = rs1_val_q;
  assign bus.rs2_val  = rs2_val_q;
  assign bus.rs1_busy = rs1_busy_q;
  assign bus.rs2_busy = rs2_busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: per-cycle vector table checked through an expected
// queue, then hand-written sequences for scoreboard fill and async reset.
module tb_reg_file_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int EXP_W = DW + DW + 1 + 1 + (AW + 1);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          sb_set;
    logic [AW-1:0] sb_addr;
    logic          rd_en;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] e_v1;
    logic [DW-1:0] e_v2;
    logic          e_b1;
    logic          e_b2;
    logic [AW:0]   e_cnt;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;
  logic [EXP_W-1:0] exp_q[$];
  vec_t vecs[17];

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic we, int wa, logic [DW-1:0] wd, logic ss, int sa,
                              logic re, int r1, int r2, logic [DW-1:0] v1,
                              logic [DW-1:0] v2, logic b1, logic b2, int c);
    vec_t v;
    v.wr_en = we; v.wr_addr = AW'(wa); v.wr_data = wd;
    v.sb_set = ss; v.sb_addr = AW'(sa);
    v.rd_en = re; v.rs1 = AW'(r1); v.rs2 = AW'(r2);
    v.e_v1 = v1; v.e_v2 = v2; v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = (AW+1)'(c);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Scoreboard side: pop one expectation and compare all outputs.
  task automatic compare_out(input string tag);
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".rs1_val"},  64'(bus.rs1_val),  64'(e[EXP_W-1 -: DW]));
      chk({tag, ".rs2_val"},  64'(bus.rs2_val),  64'(e[EXP_W-DW-1 -: DW]));
      chk({tag, ".rs1_busy"}, 64'(bus.rs1_busy), 64'(e[AW+2]));
      chk({tag, ".rs2_busy"}, 64'(bus.rs2_busy), 64'(e[AW+1]));
      chk({tag, ".busy_cnt"}, 64'(bus.busy_cnt), 64'(e[AW:0]));
    end
  endtask

  // Driver: apply one cycle of stimulus, queue its expectation, check after edge.
  task automatic step(input vec_t v, input string tag);
    bus.wr_en = v.wr_en; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
    bus.sb_set = v.sb_set; bus.sb_addr = v.sb_addr;
    bus.rd_en = v.rd_en; bus.rs1_addr = v.rs1; bus.rs2_addr = v.rs2;
    exp_q.push_back({v.e_v1, v.e_v2, v.e_b1, v.e_b2, v.e_cnt});
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rs1_val"},  64'(bus.rs1_val),  64'h0);
    chk({tag, ".rs2_val"},  64'(bus.rs2_val),  64'h0);
    chk({tag, ".rs1_busy"}, 64'(bus.rs1_busy), 64'h0);
    chk({tag, ".rs2_busy"}, 64'(bus.rs2_busy), 64'h0);
    chk({tag, ".busy_cnt"}, 64'(bus.busy_cnt), 64'h0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0;
    bus.rd_en = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;

    //            we wa wdata           ss sa re r1 r2  exp rs1_val                 exp rs2_val                   b1 b2 cnt
    vecs[0]  = mk(1, 5, 32'hDEADBEEF,   0, 0, 0, 0, 0,  32'h0,                      32'h0,                        0, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,          0, 0, 1, 5, 0,  32'hDEADBEEF,               32'h0,                        0, 0, 0);
    vecs[2]  = mk(1, 7, 32'h12345678,   0, 0, 1, 5, 7,  32'hDEADBEEF,               BYP ? 32'h12345678 : 32'h0,   0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,          0, 0, 1, 7, 7,  32'h12345678,               32'h12345678,                 0, 0, 0);
    vecs[4]  = mk(1, 0, 32'hFFFFFFFF,   0, 0, 0, 0, 0,  32'h12345678,               32'h12345678,                 0, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,          0, 0, 1, 0, 5,  32'h0,                      32'hDEADBEEF,                 0, 0, 0);
    vecs[6]  = mk(0, 0, 32'h0,          1, 3, 0, 0, 0,  32'h0,                      32'hDEADBEEF,                 0, 0, 1);
    vecs[7]  = mk(0, 0, 32'h0,          1, 3, 1, 3, 5,  32'h0,                      32'hDEADBEEF,                 1, 0, 1);
    vecs[8]  = mk(1, 3, 32'hAAAA5555,   1, 3, 1, 3, 3,  BYP ? 32'hAAAA5555 : 32'h0, BYP ? 32'hAAAA5555 : 32'h0,   0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,          0, 0, 1, 3, 0,  32'hAAAA5555,               32'h0,                        1, 0, 1);
    vecs[10] = mk(1, 3, 32'h00000011,   0, 0, 1, 3, 0,  BYP ? 32'h11 : 32'hAAAA5555, 32'h0,                       0, 0, 0);
    vecs[11] = mk(0, 0, 32'h0,          0, 0, 1, 3, 3,  32'h11,                     32'h11,                       0, 0, 0);
    vecs[12] = mk(0, 0, 32'h0,          1, 9, 1, 9, 9,  32'h0,                      32'h0,                        0, 0, 1);
    vecs[13] = mk(0, 0, 32'h0,          1, 0, 1, 9, 0,  32'h0,                      32'h0,                        1, 0, 1);
    vecs[14] = mk(1, 9, 32'h00000099,   1, 4, 0, 0, 0,  32'h0,                      32'h0,                        1, 0, 1);
    vecs[15] = mk(1, 4, 32'h00000044,   0, 0, 1, 9, 4,  32'h99,                     BYP ? 32'h44 : 32'h0,         0, 0, 0);
    vecs[16] = mk(1, 6, 32'h00000066,   0, 0, 0, 0, 0,  32'h99,                     BYP ? 32'h44 : 32'h0,         0, 0, 0);

    // Reset values while reset_n is held low.
    #12;
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Fill every non-zero register's busy bit; count must climb to 31.
    for (int i = 1; i < 32; i++)
      step(mk(0, 0, 32'h0, 1, i, 1, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF,
              logic'(i > 5), logic'(i > 5), i), $sformatf("fill%0d", i));
    step(mk(0, 0, 32'h0, 1, 1, 1, 5, 9, 32'hDEADBEEF, 32'h99, 1, 1, 31), "refill");

    // Asynchronous reset between edges clears all outputs at once.
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");

    // Strobes during reset are ignored.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hFFFFFFFF;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd2;
    bus.rd_en = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd2;
    @(posedge clk);
    #1;
    chk_all_zero("in_reset_edge");

    // First edge after release behaves normally; r5 was cleared by reset.
    reset_n = 1'b1;
    step(mk(1, 5, 32'hFFFFFFFF, 1, 2, 1, 5, 2, BYP ? 32'hFFFFFFFF : 32'h0, 32'h0, 0, 0, 1), "post_reset0");
    step(mk(0, 0, 32'h0, 0, 0, 1, 5, 2, 32'hFFFFFFFF, 32'h0, 0, 1, 1), "post_reset1");

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL leftover: %0d expectations never compared", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_R0, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rd_en  input  1  capture read results this cycle.
REQ-007 SHALL have ports rs1_addr, rs2_addr  input  ADDR_W  read addresses.
REQ-008 SHALL have ports rs1_val, rs2_val  output  DATA_W  registered read data.
REQ-009 SHALL have ports rs1_busy, rs2_busy  output  1  registered pending-write flag for each read port.
REQ-010 SHALL have port wr_en  input  1  write strobe.
REQ-011 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-012 SHALL have port wr_data  input  DATA_W  write data.
REQ-013 SHALL have port sb_set  input  1  mark a destination as pending; issued by the decode stage.
REQ-014 SHALL have port sb_addr  input  ADDR_W  destination to mark pending.
REQ-015 SHALL have port busy_cnt  output  ADDR_W+1  number of currently pending registers.

Function
REQ-016 SHALL write wr_data into register wr_addr on the rising edge when wr_en=1.
REQ-017 SHALL update rs1_val/rs2_val one edge after rd_en=1; outputs SHALL hold when rd_en=0.
REQ-018 SHALL ignore writes to address 0 when ZERO_R0=1; reads of address 0 SHALL return 0 and busy=0.
REQ-019 SHALL keep one busy bit per register: sb_set sets bit[sb_addr]; wr_en clears bit[wr_addr].
REQ-020 SHALL let set win when sb_set and wr_en target the same address in one cycle; busy_cnt is then unchanged.
REQ-021 SHALL capture into rsN_busy the busy bit before this edge's update, ANDed with NOT(wr_en and wr_addr==rsN_addr); a same-cycle sb_set SHALL NOT be visible.
REQ-022 SHALL change busy_cnt by +1, -1 or 0 per cycle, counting only real 0->1 and 1->0 transitions; setting an already-busy bit or clearing an idle bit SHALL NOT change it.
REQ-023 SHALL let busy_cnt reach 2**ADDR_W (2**ADDR_W-1 when ZERO_R0=1) without wrap.
REQ-024 SHALL let both read ports address the same register and return identical data.

Reset
REQ-025 SHALL, while reset_n=0, clear all registers, all busy bits, rs1_val, rs2_val, rs1_busy, rs2_busy and busy_cnt to 0, independent of clk.
REQ-026 SHALL ignore wr_en, sb_set and rd_en while reset_n=0; the first rising edge after release SHALL act normally.

Configuration
REQ-027 SHALL, with REGFILE_BYPASS_EN defined, forward wr_data to rsN_val when rd_en=1, wr_en=1 and wr_addr==rsN_addr (not address 0 when ZERO_R0=1).
REQ-028 SHALL, without REGFILE_BYPASS_EN, return the pre-write value in that case (read-before-write); rsN_busy rule REQ-021 SHALL apply unchanged.

Structure
REQ-029 SHALL place default DATA_W/ADDR_W constants and the read-port address/data typedef in shared package regfile_pkg.
REQ-030 SHALL implement the busy bits and busy_cnt in one sub-module reg_scoreboard; storage and read ports stay in reg_file_sb.

Verification
REQ-031 SHALL cover write r5=0xDEADBEEF, next cycle rd_en with rs1=5 -> rs1_val=0xDEADBEEF one edge later.
REQ-032 SHALL cover a same-cycle write r7=0x12345678 and read rs2=7 (old 0) -> rs2_val=0x12345678 with the macro, 0 without; rs2_busy=0 in both cases.
REQ-033 SHALL cover a write of 0xFFFFFFFF to r0, then a read of rs1=0 -> rs1_val=0, busy_cnt=0.
REQ-034 SHALL cover sb_set r3, then sb_set r3 again -> busy_cnt=1; then sb_set r3 with wr_en r3 together -> busy_cnt=1, r3 busy; then wr_en r3 -> busy_cnt=0.
REQ-035 SHALL cover sb_set of all 31 non-zero registers -> busy_cnt=31, no wrap; then assert reset_n=0 between edges -> all outputs 0 immediately.
